// File: rtl/add_seq_pkg.sv
// Shared definitions for the 32-bit two-pass add sequencer: operand widths
// and the sequencer state encoding.
package add_seq_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 2 * HALF_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    ADD_LO  = 3'd2,
    LOAD_HI = 3'd3,
    ADD_HI  = 3'd4,
    DONE    = 3'd5
  } seq_state_e;

  // Select the low (hi=0) or high (hi=1) half of a full-width word.
  function automatic logic [HALF_W-1:0] word_half(input logic [WORD_W-1:0] word,
                                                  input logic hi);
    return hi ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/sixteen_bit_adder.sv
// Combinational 16-bit adder with carry-in and carry-out.
module sixteen_bit_adder
  import add_seq_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              cin,
  output logic [HALF_W-1:0] sum,
  output logic              cout
);

  logic [HALF_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{HALF_W{1'b0}}, cin};
  assign sum  = full[HALF_W-1:0];
  assign cout = full[HALF_W];

endmodule

// File: rtl/system.sv
// Half-width datapath: two enabled operand registers feeding one 16-bit adder.
// Registers clear on the same synchronous active-low reset as the sequencer.
module system
  import add_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              en_a,
  input  logic              en_b,
  input  logic [HALF_W-1:0] d_a,
  input  logic [HALF_W-1:0] d_b,
  input  logic              cin,
  output logic [HALF_W-1:0] sum,
  output logic              cout
);

  logic [HALF_W-1:0] reg_a;
  logic [HALF_W-1:0] reg_b;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      reg_a <= '0;
      reg_b <= '0;
    end else begin
      if (en_a) reg_a <= d_a;
      if (en_b) reg_b <= d_b;
    end
  end

  sixteen_bit_adder u_adder (
    .a    (reg_a),
    .b    (reg_b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

endmodule

// File: rtl/add32_sequencer.sv
// 32-bit adder built by running a 16-bit datapath twice (low half, then high
// half) under a fixed six-state sequence; optional accumulate of last result.
module add32_sequencer
  import add_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_cin,
  input  logic              in_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_cout
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. in_ready is high only in IDLE, out_valid only in DONE; neither
  // depends combinationally on the partner's signal.

  seq_state_e state, state_next;

  logic [WORD_W-1:0] op_a;
  logic [WORD_W-1:0] op_b;
  logic              op_cin;
  logic              carry_q;
  logic [WORD_W-1:0] result_q;
  logic              cout_q;

  logic              en_a;
  logic              en_b;
  logic [HALF_W-1:0] d_a;
  logic [HALF_W-1:0] d_b;
  logic              dp_cin;
  logic [HALF_W-1:0] dp_sum;
  logic              dp_cout;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    en_a       = 1'b0;
    en_b       = 1'b0;
    d_a        = '0;
    d_b        = '0;
    dp_cin     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = LOAD_LO;
      end
      LOAD_LO: begin
        en_a       = 1'b1;
        en_b       = 1'b1;
        d_a        = word_half(op_a, 1'b0);
        d_b        = word_half(op_b, 1'b0);
        state_next = ADD_LO;
      end
      ADD_LO: begin
        dp_cin     = op_cin;
        state_next = LOAD_HI;
      end
      LOAD_HI: begin
        en_a       = 1'b1;
        en_b       = 1'b1;
        d_a        = word_half(op_a, 1'b1);
        d_b        = word_half(op_b, 1'b1);
        state_next = ADD_HI;
      end
      ADD_HI: begin
        dp_cin     = carry_q;
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // result_q doubles as the accumulator: at accept time it holds the last
  // completed sum, since only ADD_LO/ADD_HI ever write it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a   <= in_acc ? result_q : in_a;
            op_b   <= in_b;
            op_cin <= in_cin;
          end
        end
        ADD_LO: begin
          result_q[HALF_W-1:0] <= dp_sum;
          carry_q              <= dp_cout;
        end
        ADD_HI: begin
          result_q[WORD_W-1:HALF_W] <= dp_sum;
          cout_q                    <= dp_cout;
        end
        default: ;
      endcase
    end
  end

  system u_system (
    .clk  (clk),
    .rstn (rstn),
    .en_a (en_a),
    .en_b (en_b),
    .d_a  (d_a),
    .d_b  (d_b),
    .cin  (dp_cin),
    .sum  (dp_sum),
    .cout (dp_cout)
  );

  assign out_sum  = result_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_add32_sequencer.sv
// Bench for add32_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_add32_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_acc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add32_sequencer dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_acc    (in_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request is pending for five edges after acceptance
  // (phase 1..5, 5 = result offered); {cout,sum} expectations live in exp_q.
  logic [32:0] exp_q[$];
  int          phase  = 0;
  logic [32:0] m_last = '0;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    if (!rstn) begin
      phase  = 0;
      m_last = '0;
      exp_q.delete();
      m_live = 1'b1;
    end else if (phase == 0) begin
      if (in_valid) begin
        exp_q.push_back({1'b0, (in_acc ? m_last[31:0] : in_a)} + {1'b0, in_b} + 33'(in_cin));
        phase = 1;
      end
    end else if (phase < 5) begin
      phase = phase + 1;
    end else if (out_ready) begin
      m_last = exp_q.pop_front();
      phase  = 0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", 64'(in_ready), 64'(phase == 0));
      chk("out_valid", 64'(out_valid), 64'(phase == 5));
      if (phase == 0)
        chk("idle_hold_result", 64'({out_cout, out_sum}), 64'(m_last));
      else if (phase == 5 && exp_q.size() > 0)
        chk("done_result", 64'({out_cout, out_sum}), 64'(exp_q[0]));
    end
  end

  // Issue one request and wait for its result; lat counts edges from the
  // accepting edge (inclusive) to the first edge with out_valid high.
  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic acc, output logic [31:0] s, output logic co,
                         output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_acc = acc;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    s  = out_sum;
    co = out_cout;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [31:0] s;
  logic        co;
  int          lat;
  logic [31:0] held;

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_acc = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_sum", 64'(out_sum), 64'd0);
    chk("reset_out_cout", 64'(out_cout), 64'd0);
    rstn = 1'b1;

    // Carry propagates from the low half into the high half.
    run_req(32'h0001_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, co, lat);
    chk("lohi_carry_sum", 64'(s), 64'h0002_0000);
    chk("lohi_carry_cout", 64'(co), 64'd0);
    chk("latency", 64'(lat), 64'd5);
    release_result();

    // Carry-in ripples through both halves and out of bit 31.
    run_req(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, s, co, lat);
    chk("full_wrap_sum", 64'(s), 64'h0000_0000);
    chk("full_wrap_cout", 64'(co), 64'd1);
    chk("latency_wrap", 64'(lat), 64'd5);

    // Consumer stalls: result held, new requests refused.
    held = out_sum;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 3);
      in_a = 32'h1234_5678; in_b = 32'h1111_1111;
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_sum", 64'(out_sum), 64'(held));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result();
    chk("after_done_in_ready", 64'(in_ready), 64'd1);
    chk("after_done_out_valid", 64'(out_valid), 64'd0);
    chk("after_done_cout_hold", 64'(out_cout), 64'd1);

    // Accumulate onto a previous result.
    run_req(32'd5, 32'd10, 1'b0, 1'b0, s, co, lat);
    chk("acc_base", 64'(s), 64'd15);
    release_result();
    run_req(32'hDEAD_BEEF, 32'd20, 1'b0, 1'b1, s, co, lat);
    chk("acc_sum", 64'(s), 64'd35);
    release_result();

    // Reset while the high half is loading abandons the request.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'd100; in_b = 32'd200; in_acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midflight_rst_in_ready", 64'(in_ready), 64'd1);
    chk("midflight_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midflight_rst_out_sum", 64'(out_sum), 64'd0);
    rstn = 1'b1;
    run_req(32'd3, 32'd4, 1'b0, 1'b0, s, co, lat);
    chk("post_rst_sum", 64'(s), 64'd7);
    release_result();

    // After reset the accumulator starts from zero.
    do_reset();
    run_req(32'hFFFF_0000, 32'd7, 1'b0, 1'b1, s, co, lat);
    chk("acc_after_rst", 64'(s), 64'd7);
    release_result();

    // Randomized traffic, including busy-time requests and rare resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rstn     = ($urandom_range(0, 199) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: begin in_a = 32'hFFFF_FFFF; in_b = $urandom_range(0, 3); end
        1: begin in_a = {16'h0, 16'hFFFF}; in_b = $urandom_range(0, 2); end
        default: begin in_a = $urandom; in_b = $urandom; end
      endcase
      in_cin    = 1'($urandom_range(0, 1));
      in_acc    = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add32_sequencer.md
ADD32_SEQUENCER -- requirements
Module: add32_sequencer

Interface
REQ-001 Parameters SHALL be none; operand width is fixed at 32 bits, processed as two 16-bit halves.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request carries valid operands.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_a  input  32  operand A.
REQ-007 in_b  input  32  operand B.
REQ-008 in_cin  input  1  carry-in to bit 0.
REQ-009 in_acc  input  1  1 = replace in_a with the last completed result.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_sum  output  32  result A+B+cin mod 2^32.
REQ-013 out_cout  output  1  carry out of bit 31.

Function
REQ-014 The block SHALL sequence one internal register-pair-plus-16-bit-adder datapath through two passes per request: low halves first, then high halves.
REQ-015 FSM states SHALL be IDLE, LOAD_LO, ADD_LO, LOAD_HI, ADD_HI, DONE, in that order; each non-IDLE/non-DONE state lasts exactly one cycle.
REQ-016 IDLE: in_ready=1; on in_valid=1, latch in_a (or last result if in_acc=1), in_b and in_cin; go to LOAD_LO.
REQ-017 LOAD_LO: drive datapath d_a/d_b with low halves, en_a=en_b=1.
REQ-018 ADD_LO: en_a=en_b=0, datapath cin=latched cin; capture 16-bit sum into result[15:0] and adder carry into carry register.
REQ-019 LOAD_HI: drive high halves with en_a=en_b=1.
REQ-020 ADD_HI: en_a=en_b=0, datapath cin=carry register; capture sum into result[31:16] and carry into out_cout.
REQ-021 DONE: out_valid=1, out_sum/out_cout stable; on out_ready=1 return to IDLE.
REQ-022 Latency SHALL be exactly 5 cycles: request accepted at edge T gives out_valid=1 from cycle T+5.
REQ-023 in_ready SHALL be 0 in every state except IDLE; in_valid while busy is ignored, not queued.
REQ-024 out_ready asserted outside DONE SHALL have no effect; in_ready returns to 1 the cycle after the DONE handshake (no same-cycle bypass).
REQ-025 out_sum/out_cout SHALL hold the last completed result after leaving DONE until the next ADD_LO/ADD_HI overwrite.
REQ-026 in_acc=1 before any completed result SHALL use 0x0000_0000 as A.
REQ-027 Datapath enables SHALL never be asserted in ADD_LO, ADD_HI, DONE or IDLE.

Reset
REQ-028 rstn=0 at a rising edge SHALL force IDLE regardless of state, abandoning any in-flight request.
REQ-029 Reset values: in_ready=1 after reset release, out_valid=0, out_sum=0, out_cout=0, carry register 0, accumulator result 0.
REQ-030 rstn SHALL be forwarded unchanged to the datapath registers so they also clear to 0.

Structure
REQ-031 FSM state encoding and the half-width constant (16) SHALL live in a shared package add_seq_pkg.
REQ-032 The datapath SHALL be one instantiated sub-module, system (two 16-bit enabled registers feeding sixteen_bit_adder); the sequencer adds no arithmetic of its own.

Verification
REQ-033 0x0001_FFFF + 0x0000_0001, cin=0 -> out_sum=0x0002_0000, out_cout=0, out_valid 5 cycles after accept.
REQ-034 0xFFFF_FFFF + 0x0000_0000, cin=1 -> out_sum=0x0000_0000, out_cout=1 (carry crosses both halves).
REQ-035 out_ready held 0 for 10 cycles after result -> out_valid and out_sum stay constant, in_ready=0, second in_valid ignored.
REQ-036 rstn=0 for one edge while in LOAD_HI -> next cycle IDLE, out_valid=0, out_sum=0; fresh request 3+4 -> 7.
REQ-037 Accumulate: 5+10 then in_acc=1 with in_b=20 -> 35; reset, then in_acc=1 with in_b=7 -> 7.
